// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer: reset mode, clap direction
// encodings and the cyclic index step used by the clap path.
package mode_sequencer_pkg;

  localparam int unsigned RESET_MODE = 0;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_e;

  // Wraps explicitly at both ends so a non-power-of-2 mode count never
  // passes through an unused index code.
  function automatic int unsigned step_idx(int unsigned idx, int unsigned n_modes, dir_e dir);
    if (dir == DIR_FWD) begin
      return (idx == n_modes - 1) ? 0 : idx + 1;
    end else begin
      return (idx == 0) ? n_modes - 1 : idx - 1;
    end
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Board-side bundle of the mode sequencer: raw buttons, clap detector
// inputs and the mode outputs consumed by the datapath blocks.
interface mode_sequencer_if #(
  parameter int N_MODES = 3,
  parameter int IDX_W   = $clog2(N_MODES)
);
  logic [N_MODES-1:0] sel_i;
  logic               clap_i;
  logic               dir_i;
  logic [N_MODES-1:0] state_o;
  logic [IDX_W-1:0]   mode_idx_o;
  logic               changed_o;
  logic               holdoff_o;

  modport master (
    output sel_i, clap_i, dir_i,
    input  state_o, mode_idx_o, changed_o, holdoff_o
  );

  modport slave (
    input  sel_i, clap_i, dir_i,
    output state_o, mode_idx_o, changed_o, holdoff_o
  );
endinterface

// File: rtl/mode_sequencer_btn_debounce.sv
// One button input: 2-FF synchroniser, debounce counter and a registered
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic press_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw_i;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q2 == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      level_q <= sync_q2;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered rising-edge detect on the debounced level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer top: one-hot mode register driven by debounced per-mode
// buttons (direct jump) and by clap events (cyclic step with hold-off).
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int N_MODES         = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int IDX_W           = $clog2(N_MODES)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mode_sequencer_if.slave     bus
);
  localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic [N_MODES-1:0] press;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_next;
  logic [IDX_W-1:0]   press_idx;
  logic               press_seen;
  logic               press_multi;
  logic               changed_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               clap_acc;

  for (genvar m = 0; m < N_MODES; m++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (bus.sel_i[m]),
      .press_o(press[m])
    );
  end

  assign clap_acc = bus.clap_i && (hold_q == '0);

  // Find the pressed mode and flag simultaneous presses, which are ignored.
  always_comb begin
    press_seen  = 1'b0;
    press_multi = 1'b0;
    press_idx   = '0;
    for (int m = 0; m < N_MODES; m++) begin
      if (press[m]) begin
        if (press_seen) press_multi = 1'b1;
        press_seen = 1'b1;
        press_idx  = IDX_W'(m);
      end
    end
  end

  // Next mode: an accepted clap beats a press; otherwise hold.
  always_comb begin
    idx_next = idx_q;
    if (clap_acc) begin
      idx_next = IDX_W'(step_idx(32'(idx_q), N_MODES, dir_e'(bus.dir_i)));
    end else if (press_seen && !press_multi) begin
      idx_next = press_idx;
    end
  end

  // Mode index register and change pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= IDX_W'(RESET_MODE);
      changed_q <= 1'b0;
    end else begin
      idx_q     <= idx_next;
      changed_q <= (idx_next != idx_q);
    end
  end

  // Hold-off counter: loads on an accepted clap, then counts down to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else if (clap_acc) begin
      hold_q <= HOLD_W'(HOLDOFF_CYCLES);
    end else if (hold_q != '0) begin
      hold_q <= hold_q - HOLD_W'(1);
    end
  end

  assign bus.state_o    = {{(N_MODES-1){1'b0}}, 1'b1} << idx_q;
  assign bus.mode_idx_o = idx_q;
  assign bus.changed_o  = changed_q;
  assign bus.holdoff_o  = (hold_q != '0);

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: 4-mode instance for most scenarios and
// a 3-mode instance for the non-power-of-2 wrap.
module tb_mode_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mode_sequencer_if #(.N_MODES(4)) bus4 ();
  mode_sequencer_if #(.N_MODES(3)) bus3 ();

  mode_sequencer #(
    .N_MODES(4), .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8)
  ) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4)
  );

  mode_sequencer #(
    .N_MODES(3), .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus4.sel_i = '0; bus4.clap_i = 1'b0; bus4.dir_i = 1'b0;
    bus3.sel_i = '0; bus3.clap_i = 1'b0; bus3.dir_i = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_state",   32'(bus4.state_o),    32'h1);
    check_eq("rst_idx",     32'(bus4.mode_idx_o), 32'h0);
    check_eq("rst_changed", 32'(bus4.changed_o),  32'h0);
    check_eq("rst_holdoff", 32'(bus4.holdoff_o),  32'h0);
    rst = 1'b0;

    // 1: press of mode 2, change pulse DEBOUNCE_CYCLES+3 edges after first sample
    bus4.sel_i = 4'b0100;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_eq("t1_changed", 32'(bus4.changed_o), 32'(i == 8));
      check_eq("t1_state",   32'(bus4.state_o),   (i >= 8) ? 32'h4 : 32'h1);
    end
    check_eq("t1_idx", 32'(bus4.mode_idx_o), 32'h2);
    bus4.sel_i = '0;

    // 2: bouncing button never settles long enough
    do_reset();
    for (int c = 0; c < 32; c++) begin
      bus4.sel_i = (c < 20 && ((c / 2) % 2 == 0)) ? 4'b0010 : 4'b0000;
      tick();
      check_eq("t2_changed", 32'(bus4.changed_o), 32'h0);
    end
    check_eq("t2_state", 32'(bus4.state_o), 32'h1);

    // 3: clap held high from idx 3 re-triggers every HOLDOFF_CYCLES+1 cycles
    do_reset();
    bus4.sel_i = 4'b1000;
    repeat (8) tick();
    check_eq("t3_pre_idx", 32'(bus4.mode_idx_o), 32'h3);
    bus4.sel_i = '0;
    repeat (12) tick();
    bus4.dir_i  = 1'b0;
    bus4.clap_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq("t3_idx",     32'(bus4.mode_idx_o), (c < 9) ? 32'h0 : (c < 18) ? 32'h1 : 32'h2);
      check_eq("t3_holdoff", 32'(bus4.holdoff_o),  32'(!(c == 8 || c == 17)));
      check_eq("t3_changed", 32'(bus4.changed_o),  32'(c == 0 || c == 9 || c == 18));
    end
    bus4.clap_i = 1'b0;

    // 4a: backward clap wraps 0 -> N_MODES-1
    do_reset();
    bus4.dir_i  = 1'b1;
    bus4.clap_i = 1'b1;
    tick();
    bus4.clap_i = 1'b0;
    check_eq("t4_bwd_idx",     32'(bus4.mode_idx_o), 32'h3);
    check_eq("t4_bwd_state",   32'(bus4.state_o),    32'h8);
    check_eq("t4_bwd_changed", 32'(bus4.changed_o),  32'h1);
    tick();
    check_eq("t4_bwd_pulse_end", 32'(bus4.changed_o), 32'h0);

    // 4b: 3-mode instance wraps 2 -> 0 forward and 0 -> 2 backward
    bus3.sel_i = 3'b100;
    repeat (8) tick();
    check_eq("t4_n3_pre_idx", 32'(bus3.mode_idx_o), 32'h2);
    bus3.sel_i = '0;
    repeat (10) tick();
    bus3.dir_i  = 1'b0;
    bus3.clap_i = 1'b1;
    tick();
    bus3.clap_i = 1'b0;
    check_eq("t4_n3_fwd_idx",   32'(bus3.mode_idx_o), 32'h0);
    check_eq("t4_n3_fwd_state", 32'(bus3.state_o),    32'h1);
    repeat (9) tick();
    bus3.dir_i  = 1'b1;
    bus3.clap_i = 1'b1;
    tick();
    bus3.clap_i = 1'b0;
    check_eq("t4_n3_bwd_idx",   32'(bus3.mode_idx_o), 32'h2);
    check_eq("t4_n3_bwd_state", 32'(bus3.state_o),    32'h4);

    // 5a: two buttons pressed together are ignored
    do_reset();
    bus4.sel_i = 4'b0110;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_eq("t5_multi_changed", 32'(bus4.changed_o), 32'h0);
    end
    check_eq("t5_multi_state", 32'(bus4.state_o), 32'h1);
    bus4.sel_i = '0;

    // 5b: press pulse coinciding with an accepted clap is dropped
    do_reset();
    bus4.sel_i = 4'b1000;
    repeat (7) tick();
    bus4.dir_i  = 1'b0;
    bus4.clap_i = 1'b1;
    tick();
    bus4.clap_i = 1'b0;
    check_eq("t5_clap_idx",     32'(bus4.mode_idx_o), 32'h1);
    check_eq("t5_clap_changed", 32'(bus4.changed_o),  32'h1);
    check_eq("t5_clap_holdoff", 32'(bus4.holdoff_o),  32'h1);
    repeat (5) tick();
    check_eq("t5_press_dropped", 32'(bus4.state_o), 32'h2);
    bus4.sel_i = '0;

    // 6: reset mid-debounce and mid-hold-off, button must re-debounce
    do_reset();
    bus4.sel_i  = 4'b0100;
    bus4.dir_i  = 1'b0;
    bus4.clap_i = 1'b1;
    tick();
    bus4.clap_i = 1'b0;
    check_eq("t6_pre_idx",     32'(bus4.mode_idx_o), 32'h1);
    check_eq("t6_pre_holdoff", 32'(bus4.holdoff_o),  32'h1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("t6_rst_state",   32'(bus4.state_o),    32'h1);
    check_eq("t6_rst_idx",     32'(bus4.mode_idx_o), 32'h0);
    check_eq("t6_rst_changed", 32'(bus4.changed_o),  32'h0);
    check_eq("t6_rst_holdoff", 32'(bus4.holdoff_o),  32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq("t6_changed", 32'(bus4.changed_o), 32'(i == 8));
      check_eq("t6_state",   32'(bus4.state_o),   (i >= 8) ? 32'h4 : 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Parametrised successor of the board mode-select logic.
- Holds a one-hot mode register of N_MODES entries.
- Mode changes in two ways:
  - a debounced press on one per-mode select button jumps directly to that mode;
  - an accepted clap event steps cyclically forward or backward, with a hold-off window against clap bursts.
- Sits between the raw board buttons / clap detector and the datapath blocks that consume the mode.

Parameters:
- N_MODES, 3, number of modes; legal range 2..16.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a button level is accepted; legal range >=1.
- HOLDOFF_CYCLES, 8, cycles after an accepted clap during which further claps are ignored; 0 disables hold-off.
- IDX_W, $clog2(N_MODES), width of the binary mode index.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- sel_i  in  N_MODES  raw asynchronous button levels; bit m requests mode m.
- clap_i  in  1  clap condition; synchronous to clk_i; level, sampled every cycle.
- dir_i  in  1  clap step direction; 0 = +1, 1 = -1.
- state_o  out  N_MODES  one-hot current mode, registered.
- mode_idx_o  out  IDX_W  binary index of the current mode, registered, always consistent with state_o.
- changed_o  out  1  one-cycle pulse, asserted in the cycle state_o takes a new value.
- holdoff_o  out  1  high while the hold-off counter is nonzero.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state_o = 1 (mode 0), mode_idx_o = 0, changed_o = 0, holdoff_o = 0.
  - All synchroniser stages, debounced levels and counters are cleared.
  - Reset overrides every other event in the same cycle.
  - Reset asserted mid-debounce or mid-hold-off abandons that activity; a button still held after reset must re-debounce.
- Input path, per sel bit:
  - 2-FF synchroniser.
  - Debouncer: the counter increments while the synchronised level differs from the debounced level, and clears when they match. When the count reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A registered rising-edge detector on the debounced level produces a press pulse.
- Press latency: raw sel_i[m] first sampled high at edge k, held steady -> state_o updates at edge k+DEBOUNCE_CYCLES+3.
- Clap acceptance: clap_i high and hold-off counter == 0. State updates at the same edge (single registered stage).
  - Clap is level-sampled: a clap_i held high re-triggers every HOLDOFF_CYCLES+1 cycles.
  - With HOLDOFF_CYCLES = 0 it re-triggers every cycle.
- On an accepted clap:
  - Hold-off counter loads HOLDOFF_CYCLES and decrements once per cycle to 0.
  - holdoff_o = (counter != 0).
- Next-state priority, evaluated each cycle:
  1. Accepted clap: idx <= (idx+1) mod N_MODES if dir_i = 0, else (idx-1) mod N_MODES. Wrap N_MODES-1 -> 0 and 0 -> N_MODES-1. Non-power-of-2 N_MODES must wrap explicitly, never through unused codes.
  2. Exactly one press pulse in bit m: idx <= m.
  3. Otherwise: hold.
- Simultaneous events:
  - Two or more press pulses in one cycle are ignored entirely.
  - A press pulse coinciding with an accepted clap is dropped; the clap wins.
- changed_o = 1 only when the new idx differs from the old idx. A press on the current mode gives no pulse.
- Released or bouncing buttons produce no action; only debounced rising edges count.
- state_o is derived from the stored idx, so it is one-hot by construction.

Decomposition:
- Shared include mode_seq_defs.vh holds:
  - localparams for the reset mode (0);
  - clap direction encodings DIR_FWD = 1'b0, DIR_BWD = 1'b1.
- One sub-module, btn_debounce: synchroniser, debounce counter and edge detector for one bit, with parameter DEBOUNCE_CYCLES. It is instantiated N_MODES times via generate.
- The top level holds the idx register, hold-off counter and priority logic.

Test Plan (N_MODES=4, DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8):
1. Release reset; hold sel_i=4'b0100 from edge 10 -> state_o=4'b0100, mode_idx_o=2, changed_o pulse exactly at edge 17; no other pulse.
2. sel_i[1] toggles every 2 cycles for 20 cycles, then is held low -> state_o stays 4'b0001, changed_o never asserts.
3. idx=3, dir_i=0, clap_i held high 20 cycles -> accepted claps at cycles 0, 9, 18 give idx 0, 1, 2; holdoff_o is high for the 8 cycles after each.
4. idx=0, dir_i=1, single-cycle clap -> idx=3 (wrap); then with N_MODES=3 from idx=2, dir_i=0 -> idx=0, never 3.
5. sel_i=4'b0110 pressed together and held -> no change. Separately, a debounced press of bit 3 in the same cycle as an accepted clap from idx 0 -> idx=1, and the press is dropped.
6. Assert rst_i while sel_i[2] is mid-debounce and hold-off is active -> reset values next edge; sel_i[2] still held then needs a full DEBOUNCE_CYCLES+3 cycles before the state changes.
